// File: rtl/axi_sram_pkg.sv
// Types and helpers shared by the AXI-to-SRAM read assembler and write chunk breaker.
package axi_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

    localparam int SIZE_FIELD_W = 3;

    localparam logic [SIZE_FIELD_W-1:0] SIZE_1B = 3'd1;
    localparam logic [SIZE_FIELD_W-1:0] SIZE_2B = 3'd2;
    localparam logic [SIZE_FIELD_W-1:0] SIZE_4B = 3'd3;
    localparam logic [SIZE_FIELD_W-1:0] SIZE_8B = 3'd4;

    // Byte count for an AXI size code; 0 marks an illegal code.
    function automatic logic [3:0] size_to_bytes(input logic [SIZE_FIELD_W-1:0] size);
        case (size)
            SIZE_1B: return 4'd1;
            SIZE_2B: return 4'd2;
            SIZE_4B: return 4'd4;
            SIZE_8B: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/axi_sram_rd_latency_pipe.sv
// Valid-tag shift register that follows each SRAM strobe through the fixed read latency.
module axi_sram_rd_latency_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic tag_in,
    output logic tag_out
);

    logic [DEPTH-1:0] tags;

    generate
        if (DEPTH == 1) begin : g_single
            // One stage: the tag lines up with data one cycle after the strobe.
            always_ff @(posedge clk) begin
                if (!reset) tags <= 1'b0;
                else        tags <= tag_in;
            end
        end else begin : g_multi
            // Shift the tag one stage per cycle; reset flushes in-flight tags.
            always_ff @(posedge clk) begin
                // NOTE: non-blocking so every stage takes its neighbour's old value.
                if (!reset) tags <= '0;
                else        tags <= {tags[DEPTH-2:0], tag_in};
            end
        end
    endgenerate

    assign tag_out = tags[DEPTH-1];

endmodule

// File: rtl/axi_sram_read_data_assembler.sv
// Reads 1..8 bytes from a byte-wide SRAM and packs them into one AXI read word.
module axi_sram_read_data_assembler
    import axi_sram_pkg::*;
#(
    parameter int AXI_SIZE_WIDTH  = 3,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int SRAM_DATA_WIDTH = 8,
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int SRAM_RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [AXI_SIZE_WIDTH-1:0]  req_size,
    output logic                       sram_rd_en,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [AXI_DATA_WIDTH-1:0]  rd_data,
    output logic                       rd_err,
    output logic                       busy
);

    localparam int BYTES_PER_WORD = AXI_DATA_WIDTH / SRAM_DATA_WIDTH;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    state_t                     state;
    logic [SRAM_ADDR_WIDTH-1:0] base;
    logic [3:0]                 n_bytes;
    logic [3:0]                 issue_cnt;
    logic [3:0]                 ret_cnt;
    logic [3:0]                 req_bytes;
    logic                       tag_out;
    logic                       capture;

    // Address bits above the SRAM range are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[AXI_ADDR_WIDTH-1:SRAM_ADDR_WIDTH];

    assign req_bytes = size_to_bytes(SIZE_FIELD_W'(req_size));

    // A returning byte is only meaningful while the current transaction is in flight.
    assign capture = tag_out && (state == ISSUE || state == DRAIN);

    axi_sram_rd_latency_pipe #(
        .DEPTH (SRAM_RD_LATENCY)
    ) u_latency_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (sram_rd_en),
        .tag_out (tag_out)
    );

    // Request/issue/drain/response sequencing with registered outputs and byte capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            sram_rd_en <= 1'b0;
            sram_addr  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_err     <= 1'b0;
            base       <= '0;
            n_bytes    <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
        end else begin
            if (capture) begin
                rd_data[ret_cnt[BYTE_IDX_W-1:0]*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] <= sram_rd_data;
                ret_cnt <= ret_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base      <= req_addr[SRAM_ADDR_WIDTH-1:0];
                        n_bytes   <= req_bytes;
                        rd_data   <= '0;
                        ret_cnt   <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_bytes == 4'd0) begin
                            // Illegal size: answer straight away, no SRAM traffic.
                            state     <= RESP;
                            rd_valid  <= 1'b1;
                            rd_err    <= 1'b1;
                            issue_cnt <= '0;
                        end else begin
                            // First strobe goes out in the cycle right after the accept.
                            state      <= ISSUE;
                            sram_rd_en <= 1'b1;
                            sram_addr  <= req_addr[SRAM_ADDR_WIDTH-1:0];
                            issue_cnt  <= 4'd1;
                            rd_err     <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_cnt == n_bytes) begin
                        sram_rd_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        // Modulo addressing: wrap past the top of the SRAM is intended.
                        sram_addr <= base + SRAM_ADDR_WIDTH'(issue_cnt);
                        issue_cnt <= issue_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (ret_cnt == n_bytes) begin
                        state    <= RESP;
                        rd_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rd_ready) begin
                        state     <= IDLE;
                        rd_valid  <= 1'b0;
                        rd_err    <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_read_data_assembler.sv
// Self-checking bench: one DUT with read latency 1 and one with latency 3, each on its own SRAM model.
module tb_axi_sram_read_data_assembler;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 3;
    localparam int MAW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           reset        [2];
    logic           req_valid    [2];
    logic           req_ready    [2];
    logic [AW-1:0]  req_addr     [2];
    logic [SW-1:0]  req_size     [2];
    logic           sram_rd_en   [2];
    logic [MAW-1:0] sram_addr    [2];
    logic [7:0]     sram_rd_data [2];
    logic           rd_valid     [2];
    logic           rd_ready     [2];
    logic [DW-1:0]  rd_data      [2];
    logic           rd_err       [2];
    logic           busy         [2];

    axi_sram_read_data_assembler #(.SRAM_RD_LATENCY(1)) u_dut_lat1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .sram_rd_en(sram_rd_en[0]),
        .sram_addr(sram_addr[0]), .sram_rd_data(sram_rd_data[0]), .rd_valid(rd_valid[0]),
        .rd_ready(rd_ready[0]), .rd_data(rd_data[0]), .rd_err(rd_err[0]), .busy(busy[0])
    );

    axi_sram_read_data_assembler #(.SRAM_RD_LATENCY(3)) u_dut_lat3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .sram_rd_en(sram_rd_en[1]),
        .sram_addr(sram_addr[1]), .sram_rd_data(sram_rd_data[1]), .rd_valid(rd_valid[1]),
        .rd_ready(rd_ready[1]), .rd_data(rd_data[1]), .rd_err(rd_err[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Shared SRAM contents; each DUT sees them through its own latency pipe.
    logic [7:0] mem [1024];
    logic [7:0] dpipe0 [4];
    logic [7:0] dpipe1 [4];

    always @(posedge clk) begin
        dpipe0[0] <= sram_rd_en[0] ? mem[sram_addr[0]] : 8'hEE;
        dpipe1[0] <= sram_rd_en[1] ? mem[sram_addr[1]] : 8'hEE;
        for (int i = 1; i < 4; i++) begin
            dpipe0[i] <= dpipe0[i-1];
            dpipe1[i] <= dpipe1[i-1];
        end
    end
    assign sram_rd_data[0] = dpipe0[0];
    assign sram_rd_data[1] = dpipe1[2];

    // Strobe monitor: address and cycle of every SRAM read seen by each DUT.
    logic [MAW-1:0] sq_addr [2][$];
    int             sq_cyc  [2][$];
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (sram_rd_en[g] === 1'b1) begin
                sq_addr[g].push_back(sram_addr[g]);
                sq_cyc[g].push_back(cyc);
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte count, packed word and latency straight from the size rules.
    function automatic int model_bytes(input logic [2:0] size);
        return (size >= 3'd1 && size <= 3'd4) ? (1 << (size - 3'd1)) : 0;
    endfunction

    function automatic logic [63:0] model_data(input logic [31:0] addr, input logic [2:0] size);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < model_bytes(size); i++)
            w[8*i +: 8] = mem[(int'(addr[9:0]) + i) % 1024];
        return w;
    endfunction

    function automatic int model_lat(input int g, input logic [2:0] size);
        int n;
        n = model_bytes(size);
        return (n == 0) ? 0 : n + lat_of(g) + 1;
    endfunction

    // One full transaction; latency is counted in clock edges from the accept edge to the
    // edge that raises rd_valid (0 = visible in the very first cycle after accept).
    task automatic run_req(input int g, input logic [31:0] addr, input logic [2:0] size,
                           input int hold, input logic [63:0] exp_data, input logic exp_err,
                           input int exp_lat, input string name);
        int t;
        int a;
        int n;
        n = model_bytes(size);
        t = 0;
        while (req_ready[g] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, " req_ready idle"}, 64'(req_ready[g]), 64'd1);
        sq_addr[g].delete();
        sq_cyc[g].delete();
        rd_ready[g]  = (hold == 0);
        req_valid[g] = 1'b1;
        req_addr[g]  = addr;
        req_size[g]  = size;
        @(negedge clk);
        a = cyc;
        req_valid[g] = 1'b0;
        req_addr[g]  = $urandom;
        req_size[g]  = 3'($urandom);
        t = 0;
        while (rd_valid[g] !== 1'b1 && t < 40) begin
            check({name, " req_ready busy"}, 64'(req_ready[g]), 64'd0);
            @(negedge clk);
            t++;
        end
        check({name, " rd_valid"}, 64'(rd_valid[g]), 64'd1);
        check({name, " latency"}, 64'(cyc - a), 64'(exp_lat));
        check({name, " rd_data"}, rd_data[g], exp_data);
        check({name, " rd_err"}, 64'(rd_err[g]), 64'(exp_err));
        check({name, " busy"}, 64'(busy[g]), 64'd1);
        check({name, " strobes"}, 64'(sq_addr[g].size()), 64'(n));
        for (int i = 0; i < n && i < sq_addr[g].size(); i++) begin
            check({name, " strobe addr"}, 64'(sq_addr[g][i]), 64'(10'(addr[9:0] + 10'(i))));
            check({name, " strobe cycle"}, 64'(sq_cyc[g][i]), 64'(a + i));
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({name, " hold valid"}, 64'(rd_valid[g]), 64'd1);
            check({name, " hold data"}, rd_data[g], exp_data);
            check({name, " hold err"}, 64'(rd_err[g]), 64'(exp_err));
            check({name, " hold req_ready"}, 64'(req_ready[g]), 64'd0);
        end
        rd_ready[g] = 1'b1;
        @(negedge clk);
        check({name, " valid dropped"}, 64'(rd_valid[g]), 64'd0);
        check({name, " req_ready back"}, 64'(req_ready[g]), 64'd1);
        rd_ready[g] = 1'b0;
    endtask

    task automatic check_reset_state(input int g, input string name);
        check({name, " req_ready"}, 64'(req_ready[g]), 64'd1);
        check({name, " sram_rd_en"}, 64'(sram_rd_en[g]), 64'd0);
        check({name, " sram_addr"}, 64'(sram_addr[g]), 64'd0);
        check({name, " rd_valid"}, 64'(rd_valid[g]), 64'd0);
        check({name, " rd_data"}, rd_data[g], 64'd0);
        check({name, " rd_err"}, 64'(rd_err[g]), 64'd0);
        check({name, " busy"}, 64'(busy[g]), 64'd0);
    endtask

    typedef struct {
        int          g;
        logic [31:0] addr;
        logic [2:0]  size;
        int          hold;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Hand-derived expectations assume mem[k] = k + 0x10 (mod 256).
        vecs[0] = '{0, 32'h0000_0020, 3'd4, 0, 64'h3736_3534_3332_3130, 1'b0, 10};
        vecs[1] = '{0, 32'hABCD_03FF, 3'd2, 0, 64'h0000_0000_0000_100F, 1'b0, 4};
        vecs[2] = '{0, 32'h0000_0100, 3'd3, 5, 64'h0000_0000_1312_1110, 1'b0, 6};
        vecs[3] = '{0, 32'h0000_0040, 3'd0, 0, 64'h0, 1'b1, 0};
        vecs[4] = '{0, 32'h0000_0040, 3'd7, 2, 64'h0, 1'b1, 0};
        vecs[5] = '{1, 32'h0000_0008, 3'd3, 0, 64'h0000_0000_1B1A_1918, 1'b0, 8};
        vecs[6] = '{1, 32'h0000_03FE, 3'd4, 1, 64'h1514_1312_1110_0F0E, 1'b0, 12};
        vecs[7] = '{0, 32'h0000_0007, 3'd1, 3, 64'h0000_0000_0000_0017, 1'b0, 3};

        for (int k = 0; k < 1024; k++) mem[k] = 8'(k + 16);
        for (int g = 0; g < 2; g++) begin
            reset[g]     = 1'b0;
            req_valid[g] = 1'b0;
            req_addr[g]  = '0;
            req_size[g]  = '0;
            rd_ready[g]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_state(0, "reset lat1");
        check_reset_state(1, "reset lat3");
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++)
            run_req(vecs[v].g, vecs[v].addr, vecs[v].size, vecs[v].hold,
                    vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat, $sformatf("vec%0d", v));

        // Abort an 8-byte read in the middle of its issue phase.
        rd_ready[0]  = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h30;
        req_size[0]  = 3'd4;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("abort mid issue busy", 64'(busy[0]), 64'd1);
        check("abort mid issue strobe", 64'(sram_rd_en[0]), 64'd1);
        reset[0] = 1'b0;
        @(negedge clk);
        check_reset_state(0, "abort");
        reset[0] = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (rd_valid[0] === 1'b1 || sram_rd_en[0] === 1'b1) seen++;
            end
            check("abort no late response", 64'(seen), 64'd0);
        end
        run_req(0, 32'h05, 3'd1, 0, 64'h15, 1'b0, 3, "after abort");

        // Randomized traffic against the reference model, fresh SRAM contents.
        for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
        for (int r = 0; r < 40; r++) begin
            int          g;
            logic [31:0] addr;
            logic [2:0]  size;
            g    = r % 2;
            addr = $urandom;
            size = 3'($urandom_range(0, 7));
            run_req(g, addr, size, int'($urandom_range(0, 3)), model_data(addr, size),
                    (model_bytes(size) == 0), model_lat(g, size), $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
